// File: rtl/score_text_source.sv
// Score text line for the overlay: binary score -> decimal via serial double dabble,
// committed during vblank into a "SCORE nnnnn" buffer and served as 8x16 font rows.
module score_text_source #(
    parameter int WIDTH       = 32,
    parameter int SCORE_BITS  = 16,
    parameter int DIGITS      = 5,
    parameter int DIGIT_POS   = 6,
    parameter int BLANK_ZEROS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SCORE_BITS-1:0] score,
    input  logic                  score_valid,
    input  logic                  vblnk,
    input  logic [7:0]            char_xy,
    input  logic [3:0]            char_line,
    output logic [7:0]            char_line_pixels,
    output logic                  busy,
    output logic                  done
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(SCORE_BITS + 1);
    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] ZERO  = 8'h30;
    localparam logic [7:0] NINE  = 8'h39;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] SAT_LIMIT = pow10(DIGITS);

    // Reset contents of a cell: label, digits showing zero, spaces elsewhere.
    function automatic logic [7:0] init_char(input int i);
        logic [7:0] c;
        case (i)
            0:       c = 8'h53;
            1:       c = 8'h43;
            2:       c = 8'h4F;
            3:       c = 8'h52;
            4:       c = 8'h45;
            default: c = SPACE;
        endcase
        if (i == DIGIT_POS + DIGITS - 1)
            c = ZERO;
        else if (i >= DIGIT_POS && i < DIGIT_POS + DIGITS && BLANK_ZEROS == 0)
            c = ZERO;
        return c;
    endfunction

    function automatic logic [7:0] font_row(input logic [7:0] code, input logic [3:0] row);
        logic [127:0] g;
        case (code)
            8'h30:   g = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
            8'h31:   g = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
            8'h32:   g = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
            8'h33:   g = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
            8'h34:   g = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
            8'h35:   g = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
            8'h36:   g = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
            8'h37:   g = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
            8'h38:   g = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
            8'h39:   g = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
            8'h53:   g = 128'h0000_7CC6_C660_380C_06C6_C67C_0000_0000;
            8'h43:   g = 128'h0000_3C66_C2C0_C0C0_C0C2_663C_0000_0000;
            8'h4F:   g = 128'h0000_7CC6_C6C6_C6C6_C6C6_C67C_0000_0000;
            8'h52:   g = 128'h0000_FC66_6666_7C6C_6666_66E6_0000_0000;
            8'h45:   g = 128'h0000_FE66_6268_7868_6062_66FE_0000_0000;
            default: g = '0;
        endcase
        return g[8 * (15 - int'(row)) +: 8];
    endfunction

    typedef enum logic [1:0] {IDLE, CONVERT, WAIT_VBLNK, COMMIT} state_t;

    state_t                state_reg, state_next;
    logic [SCORE_BITS-1:0] bin_reg;
    logic [BCD_W-1:0]      bcd_reg;
    logic [BCD_W-1:0]      bcd_adj;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  sat_reg;
    logic                  pending_reg;
    logic [SCORE_BITS-1:0] pending_val_reg;
    logic                  load;
    logic [SCORE_BITS-1:0] load_value;
    logic [DIGITS-1:0]     upper_zero;
    logic [7:0]            digit_char [DIGITS];
    logic [7:0]            buffer [WIDTH];
    logic [7:0]            cell_code;
    logic [7:0]            code_reg;
    logic [3:0]            row_reg;

    always_ff @(posedge clk) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:       if (score_valid) state_next = CONVERT;
            CONVERT:    if (cnt_reg == CNT_W'(SCORE_BITS - 1)) state_next = WAIT_VBLNK;
            WAIT_VBLNK: if (vblnk) state_next = COMMIT;
            COMMIT:     state_next = (pending_reg || score_valid) ? CONVERT : IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg != IDLE);
        done = (state_reg == COMMIT);
    end

    // A request arriving during COMMIT is newer than any stored one, so it wins.
    assign load       = (state_reg == IDLE && score_valid) ||
                        (state_reg == COMMIT && (pending_reg || score_valid));
    assign load_value = score_valid ? score : pending_val_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            bin_reg         <= '0;
            bcd_reg         <= '0;
            cnt_reg         <= '0;
            sat_reg         <= 1'b0;
            pending_reg     <= 1'b0;
            pending_val_reg <= '0;
        end else begin
            if (load) begin
                bin_reg <= load_value;
                bcd_reg <= '0;
                cnt_reg <= '0;
                sat_reg <= (64'(load_value) >= SAT_LIMIT);
            end else if (state_reg == CONVERT) begin
                bcd_reg <= {bcd_adj[BCD_W-2:0], bin_reg[SCORE_BITS-1]};
                bin_reg <= bin_reg << 1;
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (state_reg == COMMIT) begin
                pending_reg <= 1'b0;
            end else if (state_reg != IDLE && score_valid) begin
                pending_reg     <= 1'b1;
                pending_val_reg <= score;
            end
        end
    end

    // upper_zero[i]: digit i and every more significant digit are zero.
    always_comb begin
        logic run;
        run        = 1'b1;
        upper_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run           = run && (bcd_reg[4*i +: 4] == 4'd0);
            upper_zero[i] = run;
        end
    end

    genvar gi;
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [3:0] nib;
        logic       blank;
        assign nib                 = bcd_reg[4*gi +: 4];
        assign bcd_adj[4*gi +: 4]  = (nib >= 4'd5) ? nib + 4'd3 : nib;
        assign blank               = (BLANK_ZEROS != 0) && (gi != 0) && upper_zero[gi];
        assign digit_char[gi]      = sat_reg ? NINE : (blank ? SPACE : ZERO + {4'd0, nib});
    end

    // Only digit cells hold state; label and padding cells are fixed at their reset value.
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
        if (gi >= DIGIT_POS && gi < DIGIT_POS + DIGITS) begin : g_digit_cell
            logic [7:0] cell_reg;
            always_ff @(posedge clk) begin
                if (!rst)
                    cell_reg <= init_char(gi);
                else if (state_reg == COMMIT)
                    cell_reg <= digit_char[DIGIT_POS + DIGITS - 1 - gi];
            end
            assign buffer[gi] = cell_reg;
        end else begin : g_fixed_cell
            assign buffer[gi] = init_char(gi);
        end
    end

    always_comb begin
        cell_code = SPACE;
        for (int i = 0; i < WIDTH; i++)
            if (int'(char_xy) == i) cell_code = buffer[i];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            code_reg         <= SPACE;
            row_reg          <= '0;
            char_line_pixels <= '0;
        end else begin
            code_reg         <= cell_code;
            row_reg          <= char_line;
            char_line_pixels <= font_row(code_reg, row_reg);
        end
    end
endmodule

// File: tb/tb_score_text_source.sv
// Directed bench for score_text_source: lookup latency/contents, conversion timing,
// blanking, saturation (DIGITS=4 instance), pending requests and mid-conversion reset.
module tb_score_text_source;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] score;
    logic        score_valid, score_valid4, vblnk;
    logic [7:0]  char_xy;
    logic [3:0]  char_line;
    logic [7:0]  pix, pix4;
    logic        busy, done, busy4, done4;

    always #5 clk = ~clk;

    score_text_source dut (
        .clk(clk), .rst(rst), .score(score), .score_valid(score_valid), .vblnk(vblnk),
        .char_xy(char_xy), .char_line(char_line), .char_line_pixels(pix),
        .busy(busy), .done(done)
    );

    score_text_source #(.DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .score(score), .score_valid(score_valid4), .vblnk(vblnk),
        .char_xy(char_xy), .char_line(char_line), .char_line_pixels(pix4),
        .busy(busy4), .done(done4)
    );

    typedef struct {
        int    score;
        bit    use4;
        string digits;
    } vec_t;

    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] exp_main [32];
    logic [7:0] exp4 [32];

    int done_cnt = 0;
    int busy_gap = 0;
    bit mon_en = 1'b0;

    always @(negedge clk) begin
        if (!mon_en) begin
            done_cnt <= 0;
            busy_gap <= 0;
        end else begin
            if (done) done_cnt <= done_cnt + 1;
            if (done_cnt == 1 && !done && !busy) busy_gap <= busy_gap + 1;
        end
    end

    function automatic logic [7:0] glyph_row(input logic [7:0] ch, input int row);
        logic [127:0] g;
        case (ch)
            8'h30:   g = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
            8'h31:   g = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
            8'h32:   g = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
            8'h33:   g = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
            8'h34:   g = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
            8'h35:   g = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
            8'h36:   g = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
            8'h37:   g = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
            8'h38:   g = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
            8'h39:   g = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
            8'h53:   g = 128'h0000_7CC6_C660_380C_06C6_C67C_0000_0000;
            8'h43:   g = 128'h0000_3C66_C2C0_C0C0_C0C2_663C_0000_0000;
            8'h4F:   g = 128'h0000_7CC6_C6C6_C6C6_C6C6_C67C_0000_0000;
            8'h52:   g = 128'h0000_FC66_6666_7C6C_6666_66E6_0000_0000;
            8'h45:   g = 128'h0000_FE66_6268_7868_6062_66FE_0000_0000;
            default: g = '0;
        endcase
        return g[8 * (15 - row) +: 8];
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reset_lines();
        for (int i = 0; i < 32; i++) begin
            exp_main[i] = 8'h20;
            exp4[i]     = 8'h20;
        end
        exp_main[0] = 8'h53; exp_main[1] = 8'h43; exp_main[2] = 8'h4F;
        exp_main[3] = 8'h52; exp_main[4] = 8'h45;
        for (int i = 0; i < 5; i++) exp4[i] = exp_main[i];
        exp_main[10] = 8'h30;
        exp4[9]      = 8'h30;
    endtask

    task automatic set_digits(input bit use4, input string s);
        for (int k = 0; k < s.len(); k++) begin
            if (use4) exp4[6 + k] = s[k];
            else      exp_main[6 + k] = s[k];
        end
    endtask

    // Streams one lookup per cycle; each result is checked exactly two edges later.
    task automatic sweep(input bit use4, input int first, input int last,
                         input int row0, input int row_step);
        logic [7:0] exp_pix [64];
        int         xy_hist [64];
        int         row_hist [64];
        int         n;
        n = last - first + 1;
        for (int j = 0; j < n + 2; j++) begin
            if (j >= 2)
                chk($sformatf("%s xy=%0d row=%0d", use4 ? "pix4" : "pix",
                              xy_hist[j-2], row_hist[j-2]),
                    int'(use4 ? pix4 : pix), int'(exp_pix[j-2]));
            if (j < n) begin
                int         xy, row;
                logic [7:0] ch;
                xy  = first + j;
                row = (row0 + j * row_step) % 16;
                ch  = (xy < 32) ? (use4 ? exp4[xy] : exp_main[xy]) : 8'h20;
                char_xy     = 8'(xy);
                char_line   = 4'(row);
                exp_pix[j]  = glyph_row(ch, row);
                xy_hist[j]  = xy;
                row_hist[j] = row;
            end
            step();
        end
    endtask

    task automatic wait_done(input bit use4, input int limit, output int cycles);
        cycles = -1;
        for (int n = 1; n <= limit; n++) begin
            step();
            score_valid  = 1'b0;
            score_valid4 = 1'b0;
            if (use4 ? done4 : done) begin
                cycles = n;
                break;
            end
        end
    endtask

    initial begin
        vec_t vecs [14];
        int   cyc;
        int   bad;

        vecs[0]  = '{7,     1'b0, "    7"};
        vecs[1]  = '{0,     1'b0, "    0"};
        vecs[2]  = '{65535, 1'b0, "65535"};
        vecs[3]  = '{10,    1'b0, "   10"};
        vecs[4]  = '{10000, 1'b0, "10000"};
        vecs[5]  = '{909,   1'b0, "  909"};
        vecs[6]  = '{4096,  1'b0, " 4096"};
        vecs[7]  = '{65535, 1'b1, "9999"};
        vecs[8]  = '{10000, 1'b1, "9999"};
        vecs[9]  = '{9999,  1'b1, "9999"};
        vecs[10] = '{1234,  1'b1, "1234"};
        vecs[11] = '{5,     1'b1, "   5"};
        vecs[12] = '{0,     1'b1, "   0"};
        vecs[13] = '{860,   1'b1, " 860"};

        rst = 1'b0; score = '0; score_valid = 1'b0; score_valid4 = 1'b0;
        vblnk = 1'b0; char_xy = '0; char_line = '0;
        set_reset_lines();
        step(); step();
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset pixels", int'(pix), 0);
        chk("reset busy4", int'(busy4), 0);
        rst = 1'b1;
        step();

        sweep(1'b0, 0, 33, 3, 0);
        sweep(1'b0, 200, 200, 4, 0);
        sweep(1'b1, 6, 10, 5, 1);

        // Commit must wait for vblank while the old digits stay visible.
        score = 16'd12345; score_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            score_valid = 1'b0;
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        sweep(1'b0, 6, 10, 3, 2);
        for (int i = 0; i < 70; i++) begin
            step();
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        chk("busy held, no done before vblnk", bad, 0);
        vblnk = 1'b1;
        wait_done(1'b0, 5, cyc);
        chk("done after vblnk rises", cyc, 1);
        step();
        chk("busy after 12345 commit", int'(busy), 0);
        chk("done single pulse", int'(done), 0);
        set_digits(1'b0, "12345");
        sweep(1'b0, 0, 10, 0, 1);

        for (int v = 0; v < 14; v++) begin
            score = 16'(vecs[v].score);
            if (vecs[v].use4) score_valid4 = 1'b1;
            else              score_valid  = 1'b1;
            wait_done(vecs[v].use4, 40, cyc);
            chk($sformatf("latency score=%0d", vecs[v].score), cyc, 18);
            step();
            chk($sformatf("busy after score=%0d", vecs[v].score),
                int'(vecs[v].use4 ? busy4 : busy), 0);
            chk($sformatf("done after score=%0d", vecs[v].score),
                int'(vecs[v].use4 ? done4 : done), 0);
            set_digits(vecs[v].use4, vecs[v].digits);
            sweep(vecs[v].use4, 6, 10, 2 + v, 1);
        end

        // Two requests during CONVERT: the last one is converted right after the first commit.
        mon_en = 1'b1;
        score = 16'd100; score_valid = 1'b1;
        step(); score_valid = 1'b0;
        step(); score = 16'd200; score_valid = 1'b1;
        step(); score_valid = 1'b0;
        step();
        step(); score = 16'd300; score_valid = 1'b1;
        step(); score_valid = 1'b0;
        wait_done(1'b0, 40, cyc);
        chk("first commit timing", cyc, 12);
        step();
        chk("busy stays after first commit", int'(busy), 1);
        set_digits(1'b0, "  100");
        sweep(1'b0, 6, 10, 4, 1);
        wait_done(1'b0, 40, cyc);
        chk("second commit timing", cyc, 10);
        step();
        chk("done pulse count", done_cnt, 2);
        chk("busy gap between commits", busy_gap, 0);
        chk("busy after second commit", int'(busy), 0);
        mon_en = 1'b0;
        set_digits(1'b0, "  300");
        sweep(1'b0, 6, 10, 7, 1);

        // Reset during CONVERT aborts the conversion and restores the buffer.
        char_xy = 8'd8; char_line = 4'd4;
        step(); step();
        chk("pixels before reset", int'(pix), int'(glyph_row(exp_main[8], 4)));
        score = 16'd4321; score_valid = 1'b1;
        step(); score_valid = 1'b0;
        step(); step(); step(); step();
        chk("busy mid conversion", int'(busy), 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("busy after mid reset", int'(busy), 0);
        chk("done after mid reset", int'(done), 0);
        chk("pixels after mid reset", int'(pix), 0);
        chk("busy4 after mid reset", int'(busy4), 0);
        set_reset_lines();
        sweep(1'b0, 0, 11, 1, 1);
        sweep(1'b1, 6, 10, 6, 1);
        for (int i = 0; i < 30; i++) step();
        chk("no late done after reset", int'(done), 0);
        sweep(1'b0, 6, 10, 3, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
